// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: WIDTH-bit add split into STAGES registered slices of GROUP-bit CLA blocks.
// Optional signed-overflow output is enabled by defining CLA_OVF_EN.
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTG  = (STAGES < 1) ? 1 : STAGES;
    localparam int SLICE = WIDTH / NSTG;
    localparam int NGRP  = SLICE / GROUP;
    localparam int LAST  = NSTG - 1;

    if (STAGES < 1 || (WIDTH % (NSTG * GROUP)) != 0) begin : g_cfg_err
        $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*GROUP and STAGES >= 1");
    end

    // Carry into bit i of a group, fully expanded from generate/propagate terms.
    function automatic logic la_carry(input logic [GROUP-1:0] g, input logic [GROUP-1:0] p,
                                      input logic cin, input int i);
        logic cc;
        logic t;
        cc = cin;
        for (int j = 0; j < i; j++) cc = cc & p[j];
        for (int j = 0; j < i; j++) begin
            t = g[j];
            for (int m = j + 1; m < i; m++) t = t & p[m];
            cc = cc | t;
        end
        return cc;
    endfunction

    // One slice: lookahead inside each group, group carries rippled between groups.
    function automatic logic [SLICE:0] cla_add(input logic [SLICE-1:0] x, input logic [SLICE-1:0] y,
                                               input logic ci);
        logic [SLICE:0]   r;
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic             gc;
        r  = '0;
        gc = ci;
        for (int gi = 0; gi < NGRP; gi++) begin
            g = x[gi*GROUP +: GROUP] & y[gi*GROUP +: GROUP];
            p = x[gi*GROUP +: GROUP] ^ y[gi*GROUP +: GROUP];
            for (int i = 0; i < GROUP; i++) r[gi*GROUP + i] = p[i] ^ la_carry(g, p, gc, i);
            gc = la_carry(g, p, gc, GROUP);
        end
        r[SLICE] = gc;
        return r;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] a_src [NSTG];
    logic [WIDTH-1:0] b_src [NSTG];
    logic [WIDTH-1:0] s_src [NSTG];
    logic             c_src [NSTG];
    logic             v_src [NSTG];
    logic [WIDTH-1:0] s_nx  [NSTG];
    logic             c_nx  [NSTG];
    logic [WIDTH-1:0] a_p   [NSTG];
    logic [WIDTH-1:0] b_p   [NSTG];
    logic [WIDTH-1:0] s_p   [NSTG];
    logic             c_p   [NSTG];
    logic             vld_p [NSTG];

    // Stall-all: the whole pipe moves only when the output slot can be vacated.
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        a_src[0] = a;
        b_src[0] = b;
        s_src[0] = '0;
        c_src[0] = c_in;
        v_src[0] = in_valid & in_ready;
        for (int k = 1; k < NSTG; k++) begin
            a_src[k] = a_p[k-1];
            b_src[k] = b_p[k-1];
            s_src[k] = s_p[k-1];
            c_src[k] = c_p[k-1];
            v_src[k] = vld_p[k-1];
        end
        for (int k = 0; k < NSTG; k++) begin
            s_nx[k] = s_src[k];
            {c_nx[k], s_nx[k][k*SLICE +: SLICE]} =
                cla_add(a_src[k][k*SLICE +: SLICE], b_src[k][k*SLICE +: SLICE], c_src[k]);
        end
    end

    // Stage boundary: every slice result, its carry and the pending operand bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_p[k] <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                s_p[k]   <= '0;
                c_p[k]   <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_p[k] <= v_src[k];
                a_p[k]   <= a_src[k];
                b_p[k]   <= b_src[k];
                s_p[k]   <= s_nx[k];
                c_p[k]   <= c_nx[k];
            end
        end
    end

    assign out_valid = vld_p[LAST];
    assign sum       = s_p[LAST];
    assign c_out     = c_p[LAST];

`ifdef CLA_OVF_EN
    logic ovf_nx;
    logic ovf_p;

    assign ovf_nx = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1]) &
                    (s_nx[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);

    // Stage boundary: overflow flag registered alongside the final sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_p <= 1'b0;
        else if (adv) ovf_p <= ovf_nx;
    end

    assign ovf = ovf_p;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed and random operands against an arithmetic model.
// Define CLA_OVF_EN to also exercise the overflow output.
module tb_cla_pipe_adder;
    localparam int WIDTH  = 32;
    localparam int GROUP  = 4;
    localparam int STAGES = 2;
    localparam longint SMAX = (longint'(1) <<< (WIDTH - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef CLA_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH+1:0] exp_q[$];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out)
`ifdef CLA_OVF_EN
        , .ovf(ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Expected {ovf, c_out, sum} from plain wide arithmetic.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci);
        logic [63:0] u;
        longint      s;
        logic        o;
        u = 64'(x) + 64'(y) + 64'(ci);
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        o = (s > SMAX) || (s < SMIN);
        return {o, u[WIDTH], u[WIDTH-1:0]};
    endfunction

    task automatic step();
        logic [WIDTH+1:0] e;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("sum", sum, e[WIDTH-1:0]);
                check("c_out", c_out, e[WIDTH]);
`ifdef CLA_OVF_EN
                check("ovf", ovf, e[WIDTH+1]);
`endif
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
        a = x; b = y; c_in = ci; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < maxc) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] s0;
        logic             acc;
        int               n;

        // Reset state, with out_ready low so in_ready must come from out_valid=0.
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef CLA_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // Single add with exact latency.
        send(32'd12, 32'd8, 1'b0);
        for (int i = 1; i <= STAGES; i++) begin
            #1;
            check("t1_latency", out_valid, (i == STAGES));
            if (i == STAGES) check("t1_sum", sum, 20);
            else step();
        end
        drain(10);

        // Carries that cross the slice register.
        send(32'hFFFF_FFFF, 32'h0, 1'b1);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        drain(20);

        // Back-to-back random stream at full throughput.
        for (int i = 0; i < 100; i++) begin
            a = $urandom; b = $urandom; c_in = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("t3_inflight", exp_q.size(), STAGES);
        drain(20);

        // Stall with two results in flight.
        out_ready = 1'b0;
        send($urandom, $urandom, 1'b0);
        send($urandom, $urandom, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("t4_reach", out_valid, 1);
        s0 = sum;
        a = $urandom; b = $urandom; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            check("t4_in_ready", in_ready, 0);
            check("t4_out_valid", out_valid, 1);
            check("t4_sum_hold", sum, s0);
        end
        in_valid = 1'b0;
        drain(20);

        // Reset with results in flight.
        send($urandom, $urandom, 1'b0);
        send($urandom, $urandom, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_sum", sum, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < STAGES + 4; i++) begin
            step();
            check("t5_no_stale", out_valid, 0);
        end

`ifdef CLA_OVF_EN
        // Signed overflow corners.
        send(32'h7FFF_FFFF, 32'h1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        send(32'h7FFF_FFFF, 32'h0, 1'b1);
        send(32'hFFFF_FFFF, 32'h1, 1'b0);
        drain(20);
`endif

        // Random valid/ready traffic; operands held until accepted.
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_valid && in_ready;
            step();
            if (acc || !in_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                a = $urandom; b = $urandom; c_in = 1'($urandom_range(0, 1));
            end
        end
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
